vrf_operand_collector: RTL and testbench

Operand collector that sits between issue and the banked vector register file. It accepts one vector instruction's source-register set, schedules the reads onto the data banks, and resolves bank conflicts by serialising them over successive cycles. It merges duplicate register reads, gathers the returned bf16 vectors into operand slots, and presents the complete operand bundle to the execute stage through a valid/ready handshake.

---
 rtl/vrf_operand_collector_if.sv | 55 +++++
 rtl/vrf_operand_collector.sv | 152 +++++++++++++++
 tb/tb_vrf_operand_collector.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vrf_operand_collector_if.sv
// ---------------------------------------------------------------------------
// vrf_operand_collector_if
// Bundles the issue-side request, the register-file bank port and the
// execute-side operand bundle of the operand collector.
//
// Handshake rules: a transfer on req_* or out_* happens on a rising CLK edge
// where valid and ready are both high. A source holds valid and its payload
// steady until that edge. Ready may be asserted without valid. The bank port
// has no handshake: bank_rdata is valid exactly one cycle after bank_ren.
//
// Signals
//   req_valid/req_ready  : instruction offer / collector can accept
//   req_vs               : source register per slot, slot i at [i*REG_W +: REG_W]
//   req_use              : slot needs a read
//   req_tag              : instruction tag
//   bank_ren/bank_raddr  : per-bank read enable and row
//   bank_rdata           : per-bank read data, bank b at [b*DATA_W +: DATA_W]
//   out_valid/out_ready  : operand bundle complete / execute accepts
//   out_data/out_tag     : operand vectors in slot order, bundle tag
// Modports
//   master : the environment (issue, register file, execute)
//   slave  : the collector
// ---------------------------------------------------------------------------
interface vrf_operand_collector_if #(
  parameter int NUM_OPS    = 4,
  parameter int BANK_COUNT = 4,
  parameter int BANK_IDX   = 2,
  parameter int REG_W      = 7,
  parameter int ROW_W      = REG_W - BANK_IDX,
  parameter int DATA_W     = 512,
  parameter int TAG_W      = 4
) ();
  logic                         req_valid;
  logic                         req_ready;
  logic [NUM_OPS*REG_W-1:0]     req_vs;
  logic [NUM_OPS-1:0]           req_use;
  logic [TAG_W-1:0]             req_tag;
  logic [BANK_COUNT-1:0]        bank_ren;
  logic [BANK_COUNT*ROW_W-1:0]  bank_raddr;
  logic [BANK_COUNT*DATA_W-1:0] bank_rdata;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_OPS*DATA_W-1:0]    out_data;
  logic [TAG_W-1:0]             out_tag;

  modport master (
    output req_valid, req_vs, req_use, req_tag, bank_rdata, out_ready,
    input  req_ready, bank_ren, bank_raddr, out_valid, out_data, out_tag
  );

  modport slave (
    input  req_valid, req_vs, req_use, req_tag, bank_rdata, out_ready,
    output req_ready, bank_ren, bank_raddr, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/vrf_operand_collector.sv
// ---------------------------------------------------------------------------
// vrf_operand_collector
// Takes one vector instruction's source-register set, reads the registers
// from the banked register file (one read per bank per cycle, conflicts
// serialised, duplicate registers merged into one read), gathers the
// returned vectors into operand slots and offers the complete bundle to
// execute.
//
// Ports
//   CLK       : clock, rising edge
//   nRST      : synchronous active-low reset
//   bus       : request / bank / bundle signals (slave modport)
//   busy      : collector is not IDLE
//   state_dbg : current FSM state (0 IDLE, 1 COLLECT, 2 DONE)
// ---------------------------------------------------------------------------
module vrf_operand_collector #(
  parameter int NUM_OPS    = 4,
  parameter int BANK_COUNT = 4,
  parameter int BANK_IDX   = 2,
  parameter int REG_W      = 7,
  parameter int ROW_W      = REG_W - BANK_IDX,
  parameter int DATA_W     = 512,
  parameter int TAG_W      = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  vrf_operand_collector_if.slave bus,
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [REG_W-1:0]      vs_q [NUM_OPS];
  logic [TAG_W-1:0]      tag_q;
  logic [NUM_OPS-1:0]    pending_q;
  logic [DATA_W-1:0]     slot_q [NUM_OPS];
  logic [BANK_COUNT-1:0] infl_valid_q;
  logic [NUM_OPS-1:0]    infl_mask_q [BANK_COUNT];

  logic [BANK_COUNT-1:0] issue_ren;
  logic [NUM_OPS-1:0]    issue_mask [BANK_COUNT];
  logic [ROW_W-1:0]      issue_row [BANK_COUNT];
  logic [REG_W-1:0]      win_vs [BANK_COUNT];
  logic [NUM_OPS-1:0]    joined;

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state. Leaving COLLECT once nothing is pending is safe: with no
  // pending slot nothing issues this cycle, so any read still in flight is
  // being captured at this same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = (bus.req_use != '0) ? COLLECT : DONE;
      COLLECT: if (pending_q == '0) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    busy          = (state_q != IDLE);
    state_dbg     = state_q;
  end

  // Issue: per bank, the lowest-index pending slot mapped to it wins; every
  // pending slot naming the same register rides along on that read.
  always_comb begin
    issue_ren = '0;
    joined    = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      issue_mask[b] = '0;
      issue_row[b]  = '0;
      win_vs[b]     = '0;
      if (state_q == COLLECT) begin
        // Scan downward so the lowest matching index is the last one kept.
        for (int i = NUM_OPS - 1; i >= 0; i--) begin
          if (pending_q[i] && (vs_q[i][BANK_IDX-1:0] == BANK_IDX'(b))) begin
            issue_ren[b] = 1'b1;
            win_vs[b]    = vs_q[i];
          end
        end
        issue_row[b] = win_vs[b][REG_W-1:BANK_IDX];
        for (int j = 0; j < NUM_OPS; j++) begin
          issue_mask[b][j] = issue_ren[b] && pending_q[j] && (vs_q[j] == win_vs[b]);
        end
      end
      joined = joined | issue_mask[b];
    end
  end

  assign bus.bank_ren = issue_ren;
  assign bus.out_tag  = tag_q;

  for (genvar gb = 0; gb < BANK_COUNT; gb++) begin : g_raddr
    assign bus.bank_raddr[gb*ROW_W +: ROW_W] = issue_row[gb];
  end

  for (genvar gs = 0; gs < NUM_OPS; gs++) begin : g_out
    assign bus.out_data[gs*DATA_W +: DATA_W] = slot_q[gs];
  end

  // Datapath: request latch, pending bookkeeping, in-flight tracking and
  // capture. Clearing infl_valid_q on reset drops data returning for a read
  // issued before reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      tag_q        <= '0;
      pending_q    <= '0;
      infl_valid_q <= '0;
      for (int i = 0; i < NUM_OPS; i++) begin
        vs_q[i]   <= '0;
        slot_q[i] <= '0;
      end
      for (int b = 0; b < BANK_COUNT; b++) infl_mask_q[b] <= '0;
    end else begin
      if (state_q == IDLE && bus.req_valid) begin
        tag_q     <= bus.req_tag;
        pending_q <= bus.req_use;
        for (int i = 0; i < NUM_OPS; i++) begin
          vs_q[i]   <= bus.req_vs[i*REG_W +: REG_W];
          slot_q[i] <= '0;
        end
      end else if (state_q == COLLECT) begin
        pending_q <= pending_q & ~joined;
      end
      infl_valid_q <= issue_ren;
      for (int b = 0; b < BANK_COUNT; b++) begin
        infl_mask_q[b] <= issue_mask[b];
        if (infl_valid_q[b]) begin
          for (int j = 0; j < NUM_OPS; j++) begin
            if (infl_mask_q[b][j]) slot_q[j] <= bus.bank_rdata[b*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vrf_operand_collector.sv
module tb_vrf_operand_collector;
  localparam int NUM_OPS    = 4;
  localparam int BANK_COUNT = 4;
  localparam int BANK_IDX   = 2;
  localparam int REG_W      = 7;
  localparam int ROW_W      = 5;
  localparam int DATA_W     = 512;
  localparam int TAG_W      = 4;
  localparam int W          = TAG_W + NUM_OPS*DATA_W;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       busy;
  logic [1:0] state_dbg;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  vrf_operand_collector_if #(
    .NUM_OPS(NUM_OPS), .BANK_COUNT(BANK_COUNT), .BANK_IDX(BANK_IDX),
    .REG_W(REG_W), .ROW_W(ROW_W), .DATA_W(DATA_W), .TAG_W(TAG_W)
  ) bus ();

  vrf_operand_collector #(
    .NUM_OPS(NUM_OPS), .BANK_COUNT(BANK_COUNT), .BANK_IDX(BANK_IDX),
    .REG_W(REG_W), .ROW_W(ROW_W), .DATA_W(DATA_W), .TAG_W(TAG_W)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int lat_q[$];
  int acc_q[$];
  logic [3:0]  ren_log[4096];
  logic [19:0] raddr_log[4096];

  // Register contents: every 16-bit lane encodes register number and lane.
  function automatic logic [DATA_W-1:0] reg_data(input int r);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < 32; k++) d[k*16 +: 16] = {7'(r), 5'(k), 4'hB};
    return d;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- register file model ----------------
  // Unread banks return random junk so a capture without a read shows up.
  always @(posedge CLK) begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      bus.bank_rdata[b*DATA_W +: DATA_W] <= bus.bank_ren[b]
        ? reg_data(int'(bus.bank_raddr[b*ROW_W +: ROW_W]) * BANK_COUNT + b)
        : {16{$urandom}};
    end
  end

  always @(negedge CLK) begin
    if (cyc < 4096) begin
      ren_log[cyc]   <= bus.bank_ren;
      raddr_log[cyc] <= bus.bank_raddr;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit           seen;
    bit           snap_ok;
    logic [W-1:0] snap;
    logic [W-1:0] e;
    seen = 1'b0;
    snap_ok = 1'b0;
    forever begin
      @(negedge CLK);
      if (!nRST || !bus.out_valid) begin
        seen = 1'b0;
        snap_ok = 1'b0;
      end else begin
        if (!seen) begin
          seen = 1'b1;
          if (lat_q.size() > 0) chk("latency", cyc - acc_q[0], lat_q[0]);
        end
        if (snap_ok) chk("hold_stable", int'({bus.out_tag, bus.out_data} == snap), 1);
        snap = {bus.out_tag, bus.out_data};
        snap_ok = !bus.out_ready;
        if (bus.out_ready) begin
          seen = 1'b0;
          snap_ok = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_bundle got tag=%0d exp none", bus.out_tag);
          end else begin
            e = exp_q.pop_front();
            void'(lat_q.pop_front());
            void'(acc_q.pop_front());
            chk("out_tag", int'(bus.out_tag), int'(e[W-1 -: TAG_W]));
            for (int i = 0; i < NUM_OPS; i++) begin
              checks++;
              if (bus.out_data[i*DATA_W +: DATA_W] !== e[i*DATA_W +: DATA_W]) begin
                failures++;
                $display("FAIL slot%0d tag=%0d got_lo=%h exp_lo=%h", i, bus.out_tag,
                         bus.out_data[i*DATA_W +: 64], e[i*DATA_W +: 64]);
              end
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int v0, input int v1, input int v2, input int v3,
                      input logic [3:0] use_m, input logic [3:0] tag,
                      input int lat, input bit push, output int acc);
    int           waited;
    int           vv[4];
    logic [W-1:0] e;
    vv = '{v0, v1, v2, v3};
    waited = 0;
    while (!bus.req_ready && waited < 100) begin
      @(posedge CLK); #1;
      waited++;
    end
    if (!bus.req_ready) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout got=0 exp=1");
      acc = 0;
      return;
    end
    bus.req_valid = 1'b1;
    for (int i = 0; i < NUM_OPS; i++) begin
      bus.req_vs[i*REG_W +: REG_W] = 7'(vv[i]);
      e[i*DATA_W +: DATA_W] = use_m[i] ? reg_data(vv[i]) : '0;
    end
    e[W-1 -: TAG_W] = tag;
    bus.req_use = use_m;
    bus.req_tag = tag;
    acc = cyc;
    if (push) begin
      exp_q.push_back(e);
      lat_q.push_back(lat);
      acc_q.push_back(acc);
    end
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 60) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bus.out_valid) begin
      failures++;
      $display("FAIL %s_timeout got pending=%0d exp=0", name, exp_q.size());
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int n;
    bus.req_valid = 1'b0;
    bus.req_vs    = '0;
    bus.req_use   = '0;
    bus.req_tag   = '0;
    bus.out_ready = 1'b1;
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_bank_ren", int'(bus.bank_ren), 0);
    chk("rst_bank_raddr", int'(bus.bank_raddr), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data_zero", int'(bus.out_data == '0), 1);
    chk("rst_out_tag", int'(bus.out_tag), 0);
    chk("rst_busy", int'(busy), 0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // All banks distinct
    send(0, 1, 2, 3, 4'b1111, 4'h1, 3, 1'b1, acc);
    wait_done("t1");
    chk("t1_ren_c1", int'(ren_log[acc+1]), 4'b1111);
    chk("t1_raddr_c1", int'(raddr_log[acc+1]), 0);
    chk("t1_ren_c2", int'(ren_log[acc+2]), 0);

    // Four distinct registers in bank 0
    send(0, 4, 8, 12, 4'b1111, 4'h2, 6, 1'b1, acc);
    wait_done("t2");
    for (int k = 1; k <= 4; k++) begin
      chk("t2_ren0", int'(ren_log[acc+k]), 4'b0001);
      chk("t2_row0", int'(raddr_log[acc+k][4:0]), k - 1);
    end
    chk("t2_ren_after", int'(ren_log[acc+5]), 0);

    // Merged reads: v5 x3 plus v9, both bank 1
    send(5, 5, 9, 5, 4'b1111, 4'h3, 4, 1'b1, acc);
    wait_done("t3");
    chk("t3_ren_c1", int'(ren_log[acc+1]), 4'b0010);
    chk("t3_row_c1", int'(raddr_log[acc+1][9:5]), 1);
    chk("t3_ren_c2", int'(ren_log[acc+2]), 4'b0010);
    chk("t3_row_c2", int'(raddr_log[acc+2][9:5]), 2);

    // Partial use with execute back-pressure
    bus.out_ready = 1'b0;
    send(2, 6, 3, 7, 4'b0101, 4'h4, 3, 1'b1, acc);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("t4_out_valid_seen", int'(bus.out_valid), 1);
    repeat (5) begin
      chk("t4_hold_req_ready", int'(bus.req_ready), 0);
      chk("t4_hold_out_valid", int'(bus.out_valid), 1);
      @(posedge CLK); #1;
    end
    bus.out_ready = 1'b1;
    chk("t4_req_ready_at_ready", int'(bus.req_ready), 0);
    @(posedge CLK); #1;
    chk("t4_req_ready_after", int'(bus.req_ready), 1);
    chk("t4_out_valid_after", int'(bus.out_valid), 0);
    wait_done("t4");

    // No reads at all
    send(0, 0, 0, 0, 4'b0000, 4'h7, 1, 1'b1, acc);
    wait_done("t5");
    chk("t5_ren_c1", int'(ren_log[acc+1]), 0);
    chk("t5_ren_c2", int'(ren_log[acc+2]), 0);

    // Three distinct registers in bank 1 plus one in bank 2
    send(1, 5, 9, 2, 4'b1111, 4'h5, 5, 1'b1, acc);
    wait_done("t6");

    // Reset in cycle 2 of a four-way conflict
    send(0, 4, 8, 12, 4'b1111, 4'h9, 0, 1'b0, acc);
    @(posedge CLK); #1;
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    chk("t7_state_idle", int'(state_dbg), 0);
    chk("t7_req_ready", int'(bus.req_ready), 1);
    chk("t7_bank_ren", int'(bus.bank_ren), 0);
    chk("t7_out_valid", int'(bus.out_valid), 0);
    chk("t7_busy", int'(busy), 0);
    chk("t7_out_tag", int'(bus.out_tag), 0);

    // Fresh request after reset
    send(10, 20, 10, 31, 4'b1111, 4'hA, 3, 1'b1, acc);
    wait_done("t8");
    send(13, 0, 14, 0, 4'b0101, 4'hB, 3, 1'b1, acc);
    wait_done("t9");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
